decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode stage, directly upstream of the execute stage.
- Registers one fetched instruction per cycle. Decodes the opcode/funct fields into the 12-bit operation code, reads the 32x32 register file and builds the sign-extended immediate.
- Generates the one-deep forwarding flags that execute uses to select its own previous result.
- Owns the register file write port, driven by writeback, and inserts bubbles on branch flush.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count; x0 hardwired to zero.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  32  fetched instruction word.
- instr_pc  input  XLEN  address of instr.
- instr_valid  input  1  instr/instr_pc meaningful this cycle.
- flush  input  1  taken branch/jump resolved in execute (originPc).
- wb_en  input  1  register file write enable.
- wb_rd  input  5  write address.
- wb_data  input  XLEN  write data.
- operation  output  12  {instr[30], instr[25], funct3, opcode}.
- rs1  output  XLEN  source 1 value.
- rs2  output  XLEN  source 2 value.
- imm  output  XLEN  sign-extended immediate.
- rd  output  5  destination register.
- rs1_fwd  output  1  execute uses its previous result for operand 1.
- rs2_fwd  output  1  execute uses its previous result for operand 2.
- pc  output  XLEN  instruction address.
- isBranch  output  1  conditional branch (opcode 1100011).
- illegal  output  1  only present with DECODE_ILLEGAL_TRAP_EN.

Behaviour:
- Reset (async): all outputs are cleared to a bubble and the register file is cleared to 0.
  - Bubble = ADDI x0,x0,0: operation=12'h013, rd=0, imm=0, rs1=rs2=0, pc=0, flags 0.
  - last_wr (previous-issue write tracker) is cleared.
- Latency: 1 cycle. Outputs are registered on the posedge after instr_valid is sampled.
- instr_valid=0 or flush=1 at posedge: issue a bubble. flush has priority over instr_valid.
  - Two consecutive flush cycles give two bubbles.
- Field extraction: opcode=instr[6:0], funct3=instr[14:12], rd=instr[11:7], rs1a=instr[19:15], rs2a=instr[24:20].
- Immediate, by opcode:
  - I-type (0010011, 0000011, 1100111): instr[31:20] sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: 0.
- rd output is forced to 0 for S and B types, since they write no register.
- Register read: combinational from the array, then registered.
  - Read of x0 returns 0.
  - Write-through: if wb_en and wb_rd==rs?a and wb_rd!=0 in the same cycle, the registered value is wb_data.
- Register write on posedge when wb_en and wb_rd!=0. Writes to x0 are ignored.
- Forwarding:
  - last_wr holds the rd of the previously issued non-bubble instruction (0 if bubble).
  - rs1_fwd = (rs1a==last_wr) && last_wr!=0. rs2_fwd likewise with rs2a.
  - The flags are computed for the same instruction being issued.
  - A flush-induced bubble clears last_wr.
- isBranch = 1 only for opcode 1100011.
  - JAL/JALR are not flagged; execute redirects them via its own path.
- Simultaneous wb write and flush: the write still commits, and the issued instruction is still a bubble.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - An opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, or instr[1:0]!=11, raises illegal for one cycle with the bubble.
  - A defined opcode with a reserved funct3 (load 011/110/111, store >010, branch 010/011) also raises illegal.
  - The instruction is replaced by a bubble and illegal is registered with the outputs.
- Undefined: the illegal port does not exist and unknown opcodes pass through undecoded.

Test Plan:
- Reset mid-stream with instr=ADDI x5,x0,7 valid -> outputs equal the bubble immediately (async). After release and one clock: operation=12'h013, rd=5, imm=7, pc=instr_pc.
- Write x3=0xDEADBEEF via wb, then issue ADD x4,x3,x3 -> rs1=rs2=0xDEADBEEF, operation=12'h033, rs1_fwd=rs2_fwd=0.
- Issue ADDI x6,x0,1, then SUB x7,x6,x2 -> the second issue has rs1_fwd=1, rs2_fwd=0, operation[11]=1.
- BEQ x1,x2,-8 (instr=0xFE208CE3) -> isBranch=1, imm=0xFFFFFFF8, rd=0. flush asserted next cycle -> bubble, and the following instruction reading x1 has rs1_fwd=0.
- wb_en writes x9=5 in the same cycle that ADD x10,x9,x0 is sampled -> rs1=5 (write-through). wb_rd=0 with data 0x1234 -> a later read of x0 returns 0.
- With DECODE_ILLEGAL_TRAP_EN: instr=0x0000007F -> illegal=1 for one cycle, bubble issued. Without the macro, operation[6:0]=7'h7F.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage feeding execute.
// Registers one instruction per cycle and decodes its operation code and
// sign-extended immediate. It reads the 32-entry register file with
// write-through, and produces the one-deep forwarding flags.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the illegal output. With it,
// unknown opcodes and reserved funct3 encodings are replaced by a bubble.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            instr_valid,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] pc,
  output logic            isBranch
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  localparam int unsigned RAW = 5;
  localparam logic [11:0] BUBBLE_OP  = 12'h013;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_IMM    = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] regs [NREGS];
  logic [RAW-1:0]  last_wr;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RAW-1:0]  rs1a;
  logic [RAW-1:0]  rs2a;
  logic [RAW-1:0]  rd_c;
  logic [31:0]     imm32_c;
  logic [XLEN-1:0] rs1_val_c;
  logic [XLEN-1:0] rs2_val_c;
  logic            fwd1_c;
  logic            fwd2_c;
  logic            trap_c;
  logic            issue_c;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1a   = instr[19:15];
  assign rs2a   = instr[24:20];

  // Immediate format and destination register selected by opcode
  always_comb begin
    imm32_c = '0;
    rd_c    = instr[11:7];
    case (opcode)
      OPC_IMM, OPC_LOAD, OPC_JALR:
        imm32_c = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE: begin
        imm32_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        rd_c    = '0;
      end
      OPC_BRANCH: begin
        imm32_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        rd_c    = '0;
      end
      OPC_LUI, OPC_AUIPC:
        imm32_c = {instr[31:12], 12'b0};
      OPC_JAL:
        imm32_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: ;
    endcase
  end

  // Register file read with x0 forced to zero and same-cycle write-through
  always_comb begin
    rs1_val_c = '0;
    rs2_val_c = '0;
    if (rs1a != '0) rs1_val_c = (wb_en && (wb_rd == rs1a)) ? wb_data : regs[rs1a];
    if (rs2a != '0) rs2_val_c = (wb_en && (wb_rd == rs2a)) ? wb_data : regs[rs2a];
  end

  // Execute forwards its own last result when we read the register it is writing
  always_comb begin
    fwd1_c = (rs1a == last_wr) && (last_wr != '0);
    fwd2_c = (rs2a == last_wr) && (last_wr != '0);
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Unknown opcodes, non-32-bit encodings and reserved funct3 values trap
  always_comb begin
    trap_c = (instr[1:0] != 2'b11);
    case (opcode)
      OPC_OP, OPC_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ;
      OPC_LOAD:
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) trap_c = 1'b1;
      OPC_STORE:
        if (funct3 > 3'b010) trap_c = 1'b1;
      OPC_BRANCH:
        if (funct3 == 3'b010 || funct3 == 3'b011) trap_c = 1'b1;
      default:
        trap_c = 1'b1;
    endcase
  end
`else
  assign trap_c = 1'b0;
`endif

  assign issue_c = instr_valid && !flush && !trap_c;

  // Register file; x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Issue register: decoded instruction or a bubble (ADDI x0,x0,0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operation <= BUBBLE_OP;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      rd        <= '0;
      rs1_fwd   <= 1'b0;
      rs2_fwd   <= 1'b0;
      pc        <= '0;
      isBranch  <= 1'b0;
      last_wr   <= '0;
    end else if (issue_c) begin
      operation <= {instr[30], instr[25], funct3, opcode};
      rs1       <= rs1_val_c;
      rs2       <= rs2_val_c;
      imm       <= XLEN'($signed(imm32_c));
      rd        <= rd_c;
      rs1_fwd   <= fwd1_c;
      rs2_fwd   <= fwd2_c;
      pc        <= instr_pc;
      isBranch  <= (opcode == OPC_BRANCH);
      last_wr   <= rd_c;
    end else begin
      operation <= BUBBLE_OP;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      rd        <= '0;
      rs1_fwd   <= 1'b0;
      rs2_fwd   <= 1'b0;
      pc        <= '0;
      isBranch  <= 1'b0;
      last_wr   <= '0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Trap flag travels with the bubble that replaced the bad instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal <= 1'b0;
    else       illegal <= instr_valid && !flush && trap_c;
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks plus a randomized run
// compared every cycle against a behavioural model.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] instr_pc = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [11:0] operation;
  logic [31:0] rs1, rs2, imm, pc;
  logic [4:0]  rd;
  logic        rs1_fwd, rs2_fwd, isBranch;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] pc_cnt = 32'h0000_1000;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .operation(operation), .rs1(rs1), .rs2(rs2), .imm(imm),
    .rd(rd), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .pc(pc), .isBranch(isBranch)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

`ifndef DECODE_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  logic [4:0]  mlast;
  logic [11:0] e_op;
  logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
  logic [4:0]  e_rd;
  logic        e_f1, e_f2, e_br, e_ill;

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    s = ins;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return 32'(s >>> 20);
      7'b0100011: return (32'(s >>> 20) & ~32'h1F) | 32'(ins[11:7]);
      7'b1100011: return (32'(s >>> 31) << 12) | (32'(ins[7]) << 11)
                         | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
      7'b1101111: return (32'(s >>> 31) << 20) | (ins & 32'h000F_F000)
                         | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_bad(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b0;
      7'b0000011: return (f3 == 3 || f3 == 6 || f3 == 7);
      7'b0100011: return (f3 > 2);
      7'b1100011: return (f3 == 2 || f3 == 3);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_rd == a) return wb_data;
    return mregs[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      mlast = '0;
      e_op = 12'h013; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_pc = '0;
      e_rd = '0; e_f1 = 0; e_f2 = 0; e_br = 0; e_ill = 0;
    end else begin
      bit bad, iss;
      bad = TRAP && m_bad(instr);
      iss = instr_valid && !flush && !bad;
      e_ill = instr_valid && !flush && bad;
      if (iss) begin
        e_op  = {instr[30], instr[25], instr[14:12], instr[6:0]};
        e_rs1 = m_read(instr[19:15]);
        e_rs2 = m_read(instr[24:20]);
        e_imm = m_imm(instr);
        e_pc  = instr_pc;
        e_f1  = (mlast != 0) && (instr[19:15] == mlast);
        e_f2  = (mlast != 0) && (instr[24:20] == mlast);
        e_br  = (instr[6:0] == 7'b1100011);
        e_rd  = (instr[6:0] == 7'b0100011 || instr[6:0] == 7'b1100011) ? 5'd0 : instr[11:7];
        mlast = e_rd;
      end else begin
        e_op = 12'h013; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_pc = '0;
        e_rd = '0; e_f1 = 0; e_f2 = 0; e_br = 0;
        mlast = '0;
      end
      if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("operation", 32'(operation), 32'(e_op));
      chk("rs1", rs1, e_rs1);
      chk("rs2", rs2, e_rs2);
      chk("imm", imm, e_imm);
      chk("rd", 32'(rd), 32'(e_rd));
      chk("rs1_fwd", 32'(rs1_fwd), 32'(e_f1));
      chk("rs2_fwd", 32'(rs2_fwd), 32'(e_f2));
      chk("pc", pc, e_pc);
      chk("isBranch", 32'(isBranch), 32'(e_br));
      if (TRAP) chk("illegal", 32'(illegal), 32'(e_ill));
    end
  end

  // Drive one cycle of inputs on the falling edge, return just after the rising edge
  task automatic cyc(input logic [31:0] i, input logic v, input logic f,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    instr = i; instr_valid = v; flush = f;
    wb_en = we; wb_rd = wr; wb_data = wd;
    instr_pc = pc_cnt; pc_cnt += 4;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".op"}, 32'(operation), 32'h013);
    chk({tag, ".rd"}, 32'(rd), 32'h0);
    chk({tag, ".imm"}, imm, 32'h0);
    chk({tag, ".pc"}, pc, 32'h0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_bubble("por");
    chk("por.rs1", rs1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Mid-stream asynchronous reset with ADDI x5,x0,7 held valid
    cyc(32'h0070_0293, 1, 0, 0, 0, 0);
    chk("addi.rd", 32'(rd), 32'd5);
    #1 reset = 1'b1;
    #1 chk_bubble("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rel.op", 32'(operation), 32'h013);
    chk("rel.rd", 32'(rd), 32'd5);
    chk("rel.imm", imm, 32'd7);
    chk("rel.pc", pc, instr_pc);

    // x3 = DEADBEEF, then ADD x4,x3,x3
    cyc(32'h0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF);
    cyc(32'h0031_8233, 1, 0, 0, 0, 0);
    chk("add.rs1", rs1, 32'hDEAD_BEEF);
    chk("add.rs2", rs2, 32'hDEAD_BEEF);
    chk("add.op", 32'(operation), 32'h033);
    chk("add.fwd", {30'b0, rs1_fwd, rs2_fwd}, 32'h0);

    // ADDI x6,x0,1 then SUB x7,x6,x2
    cyc(32'h0010_0313, 1, 0, 0, 0, 0);
    cyc(32'h4023_03B3, 1, 0, 0, 0, 0);
    chk("sub.rs1_fwd", 32'(rs1_fwd), 32'd1);
    chk("sub.rs2_fwd", 32'(rs2_fwd), 32'd0);
    chk("sub.op", 32'(operation), 32'h833);

    // BEQ x1,x2,-8 then flush
    cyc(32'hFE20_8CE3, 1, 0, 0, 0, 0);
    chk("beq.br", 32'(isBranch), 32'd1);
    chk("beq.imm", imm, 32'hFFFF_FFF8);
    chk("beq.rd", 32'(rd), 32'd0);
    cyc(32'h0000_85B3, 1, 1, 0, 0, 0);
    chk_bubble("flush");

    // ADDI x1,x0,3, flush, then ADD x11,x1,x0: flush forgot x1
    cyc(32'h0030_0093, 1, 0, 0, 0, 0);
    chk("addi1.rd", 32'(rd), 32'd1);
    cyc(32'h0030_0093, 1, 1, 0, 0, 0);
    chk_bubble("flush2");
    cyc(32'h0000_85B3, 1, 0, 0, 0, 0);
    chk("postflush.rs1_fwd", 32'(rs1_fwd), 32'd0);

    // Write-through of x9 while ADD x10,x9,x0 is sampled
    cyc(32'h0004_8533, 1, 0, 1, 5'd9, 32'd5);
    chk("wt.rs1", rs1, 32'd5);
    // Write to x0 is ignored
    cyc(32'h0, 0, 0, 1, 5'd0, 32'h1234);
    cyc(32'h0000_0633, 1, 0, 0, 0, 0);
    chk("x0.rs1", rs1, 32'h0);

    // Unknown opcode 0x7F
    cyc(32'h0000_007F, 1, 0, 0, 0, 0);
    if (TRAP) begin
      chk("ill.flag", 32'(illegal), 32'd1);
      chk("ill.op", 32'(operation), 32'h013);
    end else begin
      chk("ill.op", 32'(operation[6:0]), 32'h7F);
    end
    cyc(32'h0070_0293, 1, 0, 0, 0, 0);
    if (TRAP) chk("ill.clear", 32'(illegal), 32'd0);
    chk("after.rd", 32'(rd), 32'd5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] opl [10];
      logic [31:0] r, ins;
      int k;
      opl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0};
      r = $urandom;
      k = $urandom_range(0, 9);
      opl[9] = 7'($urandom);
      ins = {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             r[14:12], 5'($urandom_range(0, 7)), opl[k]};
      cyc(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
          1'($urandom), 5'($urandom_range(0, 9)), $urandom);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
